// File: rtl/execute_stage.sv
// Execute stage of the 8-bit MIPS pipeline: single-cycle ALU ops plus an
// iterative shift-add multiplier that stalls upstream while it runs.
module execute_stage #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 5
) (
  input  logic              clk3,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        alu_op,
  input  logic [REG_AW-1:0] RW_in,
  input  logic              in_valid,
  output logic              stall,
  output logic [DATA_W-1:0] ans_ex,
  output logic [REG_AW-1:0] RW_ex,
  output logic              wr_en_ex,
  output logic              out_valid,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W-1:0]   mplier;
  logic [REG_AW-1:0]   mul_rw;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;
  logic                alu_wr;
  logic                alu_upd;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [DATA_W:0]     sll_w;
  logic [DATA_W:0]     srl_w;
  logic [2:0]          shamt;

  assign stall = (state == MUL_BUSY);
  assign shamt = B[2:0];
  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} - {1'b0, B};
  // One guard bit on each shifter catches the last bit shifted out (0 for a shift of 0).
  assign sll_w = {1'b0, A} << shamt;
  assign srl_w = {A, 1'b0} >> shamt;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    alu_upd = 1'b1;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
        alu_v   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[DATA_W-1:0];
        alu_c   = diff[DATA_W];
        alu_v   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
        alu_wr  = (alu_op != OP_CMP);
      end
      OP_AND:   alu_res = A & B;
      OP_OR:    alu_res = A | B;
      OP_XOR:   alu_res = A ^ B;
      OP_NOT:   alu_res = ~A;
      OP_SLL: begin
        alu_res = sll_w[DATA_W-1:0];
        alu_c   = sll_w[DATA_W];
      end
      OP_SRL: begin
        alu_res = srl_w[DATA_W:1];
        alu_c   = srl_w[0];
      end
      OP_PASSB: alu_res = B;
      default: begin
        alu_wr  = 1'b0;
        alu_upd = 1'b0;
      end
    endcase
  end

  // MUL never reaches the ALU path: IDLE diverts it into the shift-add loop.
  always_ff @(posedge clk3) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_rw    <= '0;
      ans_ex    <= '0;
      RW_ex     <= '0;
      wr_en_ex  <= 1'b0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (alu_op == OP_MUL) begin
              mcand  <= {{DATA_W{1'b0}}, A};
              mplier <= B;
              mul_rw <= RW_in;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL_BUSY;
            end else begin
              ans_ex    <= alu_res;
              RW_ex     <= RW_in;
              wr_en_ex  <= alu_wr;
              out_valid <= 1'b1;
              if (alu_upd) begin
                flag_z <= ~|alu_res;
                flag_c <= alu_c;
                flag_v <= alu_v;
              end
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            ans_ex    <= acc_next[DATA_W-1:0];
            RW_ex     <= mul_rw;
            wr_en_ex  <= 1'b1;
            out_valid <= 1'b1;
            flag_z    <= ~|acc_next[DATA_W-1:0];
            flag_c    <= |acc_next[2*DATA_W-1:DATA_W];
            flag_v    <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_execute_stage;

  logic       clk3 = 1'b0;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] alu_op;
  logic [4:0] RW_in;
  logic       in_valid;
  logic       stall;
  logic [7:0] ans_ex;
  logic [4:0] RW_ex;
  logic       wr_en_ex;
  logic       out_valid;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;

  int checks = 0;
  int passes = 0;
  int stall_cycles;

  typedef struct packed {
    logic [7:0] ans;
    logic       z;
    logic       c;
    logic       v;
    logic       wr;
    logic       upd;
  } res_t;

  int         busy_left = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_ans = '0;
  logic [4:0] m_rw = '0;
  logic       m_wr = 1'b0;
  logic       m_z = 1'b0;
  logic       m_c = 1'b0;
  logic       m_v = 1'b0;
  res_t       mul_res = '0;
  logic [4:0] mul_rw = '0;

  execute_stage #(.DATA_W(8), .REG_AW(5)) dut (
    .clk3      (clk3),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .alu_op    (alu_op),
    .RW_in     (RW_in),
    .in_valid  (in_valid),
    .stall     (stall),
    .ans_ex    (ans_ex),
    .RW_ex     (RW_ex),
    .wr_en_ex  (wr_en_ex),
    .out_valid (out_valid),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk3 = ~clk3;

  // Reference ALU in plain integer arithmetic; MUL is a real product.
  function automatic res_t refAlu(input int op, input int a, input int b);
    res_t o;
    int r, sa, sb, sr, sh;
    o = '0;
    o.wr = 1'b1;
    o.upd = 1'b1;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    r = 0;
    case (op)
      0: begin r = a + b; o.c = (r > 255); sr = sa + sb; o.v = (sr > 127) || (sr < -128); end
      1, 9: begin
        r = a - b; o.c = (a < b); sr = sa - sb; o.v = (sr > 127) || (sr < -128);
        o.wr = (op == 1);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a << sh; o.c = (sh != 0) && (((a >> (8 - sh)) & 1) != 0); end
      7: begin r = a >> sh; o.c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
      8: begin r = a * b; o.c = (r > 255); end
      10: r = b;
      default: begin r = 0; o.wr = 1'b0; o.upd = 1'b0; end
    endcase
    o.ans = 8'(r & 255);
    o.z = ((r & 255) == 0);
    return o;
  endfunction

  task automatic produce(input res_t r, input logic [4:0] rw);
    m_valid = 1'b1;
    m_ans = r.ans;
    m_rw = rw;
    m_wr = r.wr;
    if (r.upd) begin
      m_z = r.z;
      m_c = r.c;
      m_v = r.v;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [4:0] rw);
    alu_op = op;
    A = a;
    B = b;
    RW_in = rw;
    in_valid = 1'b1;
    @(negedge clk3);
    in_valid = 1'b0;
  endtask

  // Model: MUL occupies the stage for 8 edges after acceptance, then reports.
  initial begin
    res_t r;
    forever begin
      @(posedge clk3);
      if (!rst_n) begin
        busy_left = 0;
        m_valid = 1'b0; m_ans = '0; m_rw = '0; m_wr = 1'b0;
        m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
      end else begin
        m_valid = 1'b0;
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) produce(mul_res, mul_rw);
        end else if (in_valid) begin
          r = refAlu(int'(alu_op), int'(A), int'(B));
          if (alu_op == 4'd8) begin
            busy_left = 8;
            mul_res = r;
            mul_rw = RW_in;
          end else begin
            produce(r, RW_in);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk3);
      checkOutput("stall", 32'(stall), 32'(busy_left > 0));
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      checkOutput("ans_ex", 32'(ans_ex), 32'(m_ans));
      checkOutput("RW_ex", 32'(RW_ex), 32'(m_rw));
      checkOutput("wr_en_ex", 32'(wr_en_ex), 32'(m_wr));
      checkOutput("flag_z", 32'(flag_z), 32'(m_z));
      checkOutput("flag_c", 32'(flag_c), 32'(m_c));
      checkOutput("flag_v", 32'(flag_v), 32'(m_v));
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; alu_op = '0; RW_in = '0;
    repeat (2) @(negedge clk3);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_ans", 32'(ans_ex), 0);
    checkOutput("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;

    applyStimulus(4'd0, 8'h30, 8'h50, 5'h01);
    checkOutput("add_ans", 32'(ans_ex), 'h80);
    checkOutput("add_c", 32'(flag_c), 0);
    checkOutput("add_v", 32'(flag_v), 1);
    checkOutput("add_z", 32'(flag_z), 0);
    checkOutput("add_valid", 32'(out_valid), 1);
    @(negedge clk3);
    checkOutput("add_pulse_end", 32'(out_valid), 0);

    applyStimulus(4'd1, 8'h10, 8'h20, 5'h03);
    checkOutput("sub_ans", 32'(ans_ex), 'hF0);
    checkOutput("sub_c", 32'(flag_c), 1);
    applyStimulus(4'd9, 8'h40, 8'h40, 5'h04);
    checkOutput("cmp_z", 32'(flag_z), 1);
    checkOutput("cmp_wr", 32'(wr_en_ex), 0);
    checkOutput("cmp_ans", 32'(ans_ex), 0);
    applyStimulus(4'd6, 8'h81, 8'h01, 5'h05);
    checkOutput("sll_ans", 32'(ans_ex), 'h02);
    checkOutput("sll_c", 32'(flag_c), 1);
    applyStimulus(4'd7, 8'h43, 8'h00, 5'h06);
    checkOutput("srl_ans", 32'(ans_ex), 'h43);
    checkOutput("srl_c", 32'(flag_c), 0);

    // MUL with an ADD held upstream for the whole stall
    alu_op = 4'd8; A = 8'h10; B = 8'h12; RW_in = 5'h02; in_valid = 1'b1;
    @(negedge clk3);
    alu_op = 4'd0; A = 8'h05; B = 8'h07; RW_in = 5'h07;
    stall_cycles = 0;
    while (stall && stall_cycles < 20) begin
      stall_cycles++;
      @(negedge clk3);
    end
    checkOutput("mul_stall_cycles", 32'(stall_cycles), 8);
    checkOutput("mul_valid", 32'(out_valid), 1);
    checkOutput("mul_ans", 32'(ans_ex), 'h20);
    checkOutput("mul_c", 32'(flag_c), 1);
    checkOutput("mul_rw", 32'(RW_ex), 'h02);
    @(negedge clk3);
    in_valid = 1'b0;
    checkOutput("held_add_ans", 32'(ans_ex), 'h0C);
    checkOutput("held_add_rw", 32'(RW_ex), 'h07);
    checkOutput("held_add_valid", 32'(out_valid), 1);

    // Reset on the fourth busy cycle of a MUL
    @(negedge clk3);
    alu_op = 4'd8; A = 8'h03; B = 8'h05; RW_in = 5'h09; in_valid = 1'b1;
    @(negedge clk3);
    in_valid = 1'b0;
    repeat (3) @(negedge clk3);
    rst_n = 1'b0;
    @(negedge clk3);
    checkOutput("abort_stall", 32'(stall), 0);
    checkOutput("abort_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk3);
    applyStimulus(4'd0, 8'h22, 8'h11, 5'h0A);
    checkOutput("post_abort_ans", 32'(ans_ex), 'h33);
    checkOutput("post_abort_valid", 32'(out_valid), 1);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (busy_left == 0 || !rst_n) begin
        in_valid = ($urandom_range(0, 3) != 0);
        alu_op = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
        A = 8'($urandom);
        B = 8'($urandom);
        RW_in = 5'($urandom);
      end
      @(negedge clk3);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk3);

    // Mid-stream reset held for two edges
    alu_op = 4'd0; A = 8'h7F; B = 8'h01; RW_in = 5'h1F; in_valid = 1'b1;
    @(negedge clk3);
    rst_n = 1'b0;
    repeat (2) @(negedge clk3);
    checkOutput("mid_rst_ans", 32'(ans_ex), 0);
    checkOutput("mid_rst_rw", 32'(RW_ex), 0);
    checkOutput("mid_rst_wr", 32'(wr_en_ex), 0);
    checkOutput("mid_rst_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_flags", 32'({flag_z, flag_c, flag_v}), 0);
    checkOutput("mid_rst_stall", 32'(stall), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
